hps_fpga_pingpong_mailbox: RTL

//  Multi-channel successor to the single-bit fpga_to_hps/hps_to_fpga PIO exports.

---
 rtl/hps_fpga_pingpong_mailbox.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hps_fpga_pingpong_mailbox.sv
// -----------------------------------------------------------------------------
// hps_fpga_pingpong_mailbox
//
// Multi-channel mailbox between an HPS lightweight-bridge Avalon-MM slave and
// FPGA fabric logic. Each channel has two 2-entry ping-pong buffers:
//   h2f : HPS writes words, fabric drains them over a valid/ready stream.
//   f2h : fabric fills over valid/ready, HPS reads words out.
//
// Configuration macro: PINGPONG_IRQ_EN
//   defined   - per-channel irq_en in CTRL bit 8, registered level irq output.
//   undefined - irq tied 0, CTRL bit 8 ignored, STATUS bits 8/9 read 0.
//
// Ports
//   clk_clk        single clock for all logic
//   reset_reset_n  asynchronous active-low reset
//   avs_*          Avalon-MM slave, address = {channel, reg[1:0]},
//                  read latency 1, zero write wait states
//   h2f_valid/data/ready  per-channel HPS->FPGA stream (data packed c*DATA_W)
//   f2h_valid/data/ready  per-channel FPGA->HPS stream
//   irq            level-sensitive active-high interrupt
//
// Register map per channel
//   0 H2F_DATA  W: push h2f (dropped + h2f_ovf when full)   R: 0
//   1 F2H_DATA  R: pop f2h (0 + f2h_unf when empty)         W: ignored
//   2 STATUS    R: [1:0] h2f_count [3:2] f2h_count [4] h2f_ovf [5] f2h_unf
//                  [8] irq_en [9] irq_pend
//   3 CTRL      W: [0] flush h2f [1] flush f2h [2] clear flags [8] irq_en
//               R: irq_en at bit 8
// -----------------------------------------------------------------------------
module hps_fpga_pingpong_mailbox #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 4
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic [$clog2(CHANNELS)+1:0]  avs_address,
    input  logic                         avs_read,
    input  logic                         avs_write,
    input  logic [DATA_W-1:0]            avs_writedata,
    output logic [DATA_W-1:0]            avs_readdata,
    output logic [CHANNELS-1:0]          h2f_valid,
    output logic [CHANNELS*DATA_W-1:0]   h2f_data,
    input  logic [CHANNELS-1:0]          h2f_ready,
    input  logic [CHANNELS-1:0]          f2h_valid,
    input  logic [CHANNELS*DATA_W-1:0]   f2h_data,
    output logic [CHANNELS-1:0]          f2h_ready,
    output logic                         irq
);

    localparam int CH_AW = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        REG_H2F_DATA = 2'd0,
        REG_F2H_DATA = 2'd1,
        REG_STATUS   = 2'd2,
        REG_CTRL     = 2'd3
    } reg_e;

    // ------------------------------------------------------------------
    // Bus decode. A read colliding with a write is dropped (no pop, no
    // unf) and returns 0; the write proceeds.
    // ------------------------------------------------------------------
    logic [CH_AW-1:0] sel_ch;
    reg_e             sel_reg;
    logic             rd_en;
    logic             wr_en;

    assign sel_ch  = avs_address[CH_AW+1:2];
    assign sel_reg = reg_e'(avs_address[1:0]);
    assign rd_en   = avs_read & ~avs_write;
    assign wr_en   = avs_write;

    // Per-channel views gathered for the read mux and irq.
    logic [1:0]        h2f_count_a [CHANNELS];
    logic [1:0]        f2h_count_a [CHANNELS];
    logic [DATA_W-1:0] f2h_head_a  [CHANNELS];
    logic [31:0]       status_a    [CHANNELS];
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] irq_pend;

`ifdef PINGPONG_IRQ_EN
    // CTRL bit 8 only exists when the word is wide enough to carry it.
    logic wd_irq_en;
    if (DATA_W > 8) begin : g_wd_bit8
        assign wd_irq_en = avs_writedata[8];
    end else begin : g_wd_nobit8
        assign wd_irq_en = 1'b0;
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic              hit;
        logic              ctrl_wr;

        logic [DATA_W-1:0] h2f_bank [2];
        logic              h2f_wr_sel;
        logic              h2f_rd_sel;
        logic [1:0]        h2f_count;
        logic              h2f_push_req;
        logic              h2f_pop;
        logic              h2f_push;
        logic              h2f_drop;
        logic              h2f_flush;
        logic              h2f_ovf;

        logic [DATA_W-1:0] f2h_bank [2];
        logic              f2h_wr_sel;
        logic              f2h_rd_sel;
        logic [1:0]        f2h_count;
        logic              f2h_push;
        logic              f2h_pop_req;
        logic              f2h_pop;
        logic              f2h_unf_set;
        logic              f2h_flush;
        logic              f2h_unf;

        logic              flag_clr;

        assign hit     = (sel_ch == CH_AW'(c));
        assign ctrl_wr = wr_en & hit & (sel_reg == REG_CTRL);

        assign h2f_flush = ctrl_wr & avs_writedata[0];
        assign f2h_flush = ctrl_wr & avs_writedata[1];
        assign flag_clr  = ctrl_wr & avs_writedata[2];

        // h2f: a push into a full buffer is still accepted when the fabric
        // frees a bank on the same edge.
        assign h2f_pop      = h2f_valid[c] & h2f_ready[c];
        assign h2f_push_req = wr_en & hit & (sel_reg == REG_H2F_DATA);
        assign h2f_push     = h2f_push_req & ((h2f_count != 2'd2) | h2f_pop);
        assign h2f_drop     = h2f_push_req & (h2f_count == 2'd2) & ~h2f_pop;

        // f2h: ready comes from the registered count only, so a full buffer
        // refuses pushes even while the HPS is popping.
        assign f2h_push    = f2h_valid[c] & f2h_ready[c];
        assign f2h_pop_req = rd_en & hit & (sel_reg == REG_F2H_DATA);
        assign f2h_pop     = f2h_pop_req & (f2h_count != 2'd0);
        assign f2h_unf_set = f2h_pop_req & (f2h_count == 2'd0);

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        // NOTE: the two-word banks are reset as well, so a reset discards
        // buffered data and the read path never exposes stale words.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                h2f_bank[0] <= '0;
                h2f_bank[1] <= '0;
                h2f_wr_sel  <= 1'b0;
                h2f_rd_sel  <= 1'b0;
                h2f_count   <= 2'd0;
            end else if (h2f_flush) begin
                // A concurrent fabric handshake still completes; its word is
                // simply discarded along with the rest.
                h2f_wr_sel <= 1'b0;
                h2f_rd_sel <= 1'b0;
                h2f_count  <= 2'd0;
            end else begin
                if (h2f_push) begin
                    h2f_bank[h2f_wr_sel] <= avs_writedata;
                    h2f_wr_sel           <= ~h2f_wr_sel;
                end
                if (h2f_pop) begin
                    h2f_rd_sel <= ~h2f_rd_sel;
                end
                case ({h2f_push, h2f_pop})
                    2'b10:   h2f_count <= h2f_count + 2'd1;
                    2'b01:   h2f_count <= h2f_count - 2'd1;
                    default: h2f_count <= h2f_count;
                endcase
            end
        end

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                f2h_bank[0] <= '0;
                f2h_bank[1] <= '0;
                f2h_wr_sel  <= 1'b0;
                f2h_rd_sel  <= 1'b0;
                f2h_count   <= 2'd0;
            end else if (f2h_flush) begin
                f2h_wr_sel <= 1'b0;
                f2h_rd_sel <= 1'b0;
                f2h_count  <= 2'd0;
            end else begin
                if (f2h_push) begin
                    f2h_bank[f2h_wr_sel] <= f2h_data[c*DATA_W +: DATA_W];
                    f2h_wr_sel           <= ~f2h_wr_sel;
                end
                if (f2h_pop) begin
                    f2h_rd_sel <= ~f2h_rd_sel;
                end
                case ({f2h_push, f2h_pop})
                    2'b10:   f2h_count <= f2h_count + 2'd1;
                    2'b01:   f2h_count <= f2h_count - 2'd1;
                    default: f2h_count <= f2h_count;
                endcase
            end
        end

        // Sticky flags: the set terms come last so they win over a clear.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                h2f_ovf <= 1'b0;
                f2h_unf <= 1'b0;
            end else begin
                if (flag_clr) begin
                    h2f_ovf <= 1'b0;
                    f2h_unf <= 1'b0;
                end
                if (h2f_drop)    h2f_ovf <= 1'b1;
                if (f2h_unf_set) f2h_unf <= 1'b1;
            end
        end

`ifdef PINGPONG_IRQ_EN
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                irq_en[c] <= 1'b0;
            end else if (ctrl_wr) begin
                irq_en[c] <= wd_irq_en;
            end
        end
        assign irq_pend[c] = irq_en[c] & ((f2h_count != 2'd0) | h2f_ovf | f2h_unf);
`else
        assign irq_en[c]   = 1'b0;
        assign irq_pend[c] = 1'b0;
`endif

        assign h2f_valid[c]                  = (h2f_count != 2'd0);
        assign h2f_data[c*DATA_W +: DATA_W]  = h2f_bank[h2f_rd_sel];
        assign f2h_ready[c]                  = (f2h_count != 2'd2);

        assign h2f_count_a[c] = h2f_count;
        assign f2h_count_a[c] = f2h_count;
        assign f2h_head_a[c]  = f2h_bank[f2h_rd_sel];
        assign status_a[c]    = {22'd0, irq_pend[c], irq_en[c], 2'd0,
                                 f2h_unf, h2f_ovf, f2h_count, h2f_count};
    end

    // ------------------------------------------------------------------
    // Read mux, registered for a fixed read latency of one cycle.
    // ------------------------------------------------------------------
    logic [31:0] rd_word;

    // NOTE: rd_word gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rd_word = 32'd0;
        case (sel_reg)
            REG_F2H_DATA: begin
                if (f2h_count_a[sel_ch] != 2'd0) begin
                    rd_word[DATA_W-1:0] = f2h_head_a[sel_ch];
                end
            end
            REG_STATUS: rd_word = status_a[sel_ch];
            REG_CTRL:   rd_word[8] = irq_en[sel_ch];
            default:    rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_en ? rd_word[DATA_W-1:0] : '0;
        end
    end

    // h2f_count is only observed through STATUS; keep the gathered copy
    // referenced so the channel view stays complete.
    logic [1:0] h2f_count_sel;
    assign h2f_count_sel = h2f_count_a[sel_ch];

`ifdef PINGPONG_IRQ_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |irq_pend;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule
